// File: rtl/rbb_pkg.sv
// rbb_pkg: shared FSM states, batch sizing and mdata layout for the result-batch writeback.
package rbb_pkg;
   typedef enum logic [2:0] {IDLE, ISSUE, GAP, DRAIN, DONE} state_t;
   localparam int MDATA_IDX_LSB = 0;
   function automatic int num_lines(input int addr_width);
      return 1 << addr_width;
   endfunction
endpackage

// File: rtl/rbb_wb_credit.sv
// rbb_wb_credit: counts un-responded host writes; flags full, empty and stray responses.
module rbb_wb_credit #(
   parameter int MAX_OUTSTANDING = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic dec,
   output logic full,
   output logic empty,
   output logic err
);
   localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
   logic [CW-1:0] cnt;
   assign full  = cnt == CW'(MAX_OUTSTANDING);
   assign empty = cnt == '0;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
         err <= 1'b0;
      end else begin
         if (inc && !dec) cnt <= cnt + 1'b1;
         else if (dec && !inc && !empty) cnt <= cnt - 1'b1;
         // a response with nothing outstanding is a host protocol error
         if (dec && !inc && empty) err <= 1'b1;
      end
   end
endmodule

// File: rtl/rbb_writeback.sv
// rbb_writeback: drains one result batch line by line into host cache-line writes,
// then pulses batch_done once every write has been acknowledged.
module rbb_writeback
   import rbb_pkg::*;
#(
   parameter int RBB_ADDR_WIDTH  = 6,
   parameter int RBB_DATA_WIDTH  = 512,
   parameter int CL_ADDR_WIDTH   = 32,
   parameter int MAX_OUTSTANDING = 16,
   parameter int MDATA_WIDTH     = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CL_ADDR_WIDTH-1:0]  batch_base_addr,
   input  logic                      rbb_req_valid,
   input  logic [RBB_ADDR_WIDTH-1:0] rbb_req_line_idx,
   input  logic [RBB_DATA_WIDTH-1:0] rbb_rd_dout,
   output logic                      rbb_req_ack,
   output logic                      wr_req_valid,
   output logic [CL_ADDR_WIDTH-1:0]  wr_req_addr,
   output logic [RBB_DATA_WIDTH-1:0] wr_req_data,
   output logic [MDATA_WIDTH-1:0]    wr_req_mdata,
   input  logic                      wr_almost_full,
   input  logic                      wr_rsp_valid,
   output logic                      busy,
   output logic                      batch_done,
   output logic                      rsp_err
);
   localparam logic [RBB_ADDR_WIDTH:0] LAST = (RBB_ADDR_WIDTH+1)'(num_lines(RBB_ADDR_WIDTH) - 1);
   state_t state, state_n;
   logic [CL_ADDR_WIDTH-1:0] base_r;
   logic [RBB_ADDR_WIDTH:0] sent;
   logic can_issue, full, empty;

   rbb_wb_credit #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_credit (
      .clk(clk), .reset(reset), .inc(can_issue), .dec(wr_rsp_valid),
      .full(full), .empty(empty), .err(rsp_err)
   );

   assign can_issue   = state == ISSUE && rbb_req_valid && !wr_almost_full && !full;
   assign rbb_req_ack = can_issue;
   assign busy        = state != IDLE;
   assign batch_done  = state == DONE;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = rbb_req_valid ? GAP : IDLE;
         GAP:     state_n = ISSUE;
         ISSUE:   state_n = !can_issue ? ISSUE : (sent == LAST ? DRAIN : GAP);
         // the last write is still registered for one cycle after its ack
         DRAIN:   state_n = (empty && !wr_req_valid) ? DONE : DRAIN;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         base_r       <= '0;
         sent         <= '0;
         wr_req_valid <= 1'b0;
         wr_req_addr  <= '0;
         wr_req_data  <= '0;
         wr_req_mdata <= '0;
      end else begin
         state        <= state_n;
         wr_req_valid <= can_issue;
         if (state == IDLE && rbb_req_valid) begin
            base_r <= batch_base_addr;
            sent   <= '0;
         end
         if (can_issue) begin
            sent         <= sent + 1'b1;
            wr_req_addr  <= base_r + CL_ADDR_WIDTH'(rbb_req_line_idx);
            wr_req_data  <= rbb_rd_dout;
            wr_req_mdata <= MDATA_WIDTH'(rbb_req_line_idx) << MDATA_IDX_LSB;
         end
      end
   end
endmodule

// File: tb/tb_rbb_writeback.sv
// tb_rbb_writeback: table-driven and randomized batches against a queue-based reference of the host writes.
module tb_rbb_writeback;
   localparam int AW = 2, DW = 32, CW = 32, MO = 2, MW = 16, NL = 1 << AW;

   logic clk = 0, reset = 1;
   logic [CW-1:0] batch_base_addr = '0;
   logic rbb_req_valid = 0;
   logic [AW-1:0] rbb_req_line_idx = '0;
   logic [DW-1:0] rbb_rd_dout = '0;
   logic rbb_req_ack, wr_req_valid, busy, batch_done, rsp_err;
   logic [CW-1:0] wr_req_addr;
   logic [DW-1:0] wr_req_data;
   logic [MW-1:0] wr_req_mdata;
   logic wr_almost_full = 0, wr_rsp_valid = 0;

   always #5 clk = ~clk;

   rbb_writeback #(.RBB_ADDR_WIDTH(AW), .RBB_DATA_WIDTH(DW), .CL_ADDR_WIDTH(CW),
                   .MAX_OUTSTANDING(MO), .MDATA_WIDTH(MW)) dut (
      .clk(clk), .reset(reset), .batch_base_addr(batch_base_addr),
      .rbb_req_valid(rbb_req_valid), .rbb_req_line_idx(rbb_req_line_idx),
      .rbb_rd_dout(rbb_rd_dout), .rbb_req_ack(rbb_req_ack),
      .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
      .wr_req_mdata(wr_req_mdata), .wr_almost_full(wr_almost_full),
      .wr_rsp_valid(wr_rsp_valid), .busy(busy), .batch_done(batch_done), .rsp_err(rsp_err)
   );

   typedef struct {
      logic [CW-1:0] base;
      int af_start, af_len, rsp_hold, early_exp, ack_chk;
   } vec_t;
   vec_t tbl[4];

   int vectors = 0, miscompares = 0;
   logic [DW-1:0] mem[NL];
   int idx, pend;
   bit ack_prev, err_exp;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ack"}, rbb_req_ack, 0);
      chk({tag, "_wr_valid"}, wr_req_valid, 0);
      chk({tag, "_wr_addr"}, wr_req_addr, 0);
      chk({tag, "_wr_data"}, wr_req_data, 0);
      chk({tag, "_wr_mdata"}, wr_req_mdata, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, batch_done, 0);
      chk({tag, "_rsp_err"}, rsp_err, 0);
   endtask

   // buffer model: an acked line is replaced by the next one after the following edge
   task automatic tick();
      @(posedge clk);
      #1;
      if (ack_prev) begin
         idx++;
         if (idx >= NL) rbb_req_valid = 0;
         else begin
            rbb_req_line_idx = AW'(idx);
            rbb_rd_dout = mem[idx];
         end
      end
      ack_prev = 0;
   endtask

   task automatic run_batch(input logic [CW-1:0] base, input int af_start, input int af_len,
                            input int rsp_hold, input int early_exp, input int ack_chk,
                            input int rnd, input int abort_after);
      logic [CW-1:0] qa[$];
      logic [DW-1:0] qd[$];
      int qm[$];
      int cyc = 0, nack = 0, nwr = 0, ndone = 0, extra = -1, early = 0;
      for (int i = 0; i < NL; i++) begin
         mem[i] = $urandom;
         qa.push_back(base + CW'(i));
         qd.push_back(mem[i]);
         qm.push_back(i);
      end
      batch_base_addr = base;
      idx = 0;
      rbb_req_line_idx = '0;
      rbb_rd_dout = mem[0];
      rbb_req_valid = 1;
      ack_prev = 0;
      while (cyc < 300 && extra != 0) begin
         tick();
         cyc++;
         if (rnd != 0) batch_base_addr = $urandom;
         wr_almost_full = (cyc >= af_start && cyc < af_start + af_len) || (rnd != 0 && $urandom_range(3) == 0);
         wr_rsp_valid = pend > 0 && cyc >= rsp_hold && (rnd == 0 || $urandom_range(1) == 1);
         if (wr_rsp_valid) pend--;
         #1;
         if (wr_almost_full) chk("ack_under_af", rbb_req_ack, 0);
         if (rbb_req_ack) begin
            ack_prev = 1;
            nack++;
            if (ack_chk != 0) chk("ack_cycle", 64'(cyc - 1), 64'(2 * nack - 1));
         end
         if (wr_req_valid) begin
            nwr++;
            pend++;
            if (cyc < rsp_hold) early++;
            if (qa.size() == 0) chk("extra_write", 64'(nwr), NL);
            else begin
               chk("wr_addr", wr_req_addr, qa.pop_front());
               chk("wr_data", wr_req_data, qd.pop_front());
               chk("wr_mdata", wr_req_mdata, 64'(qm.pop_front()));
            end
            chk("outstanding_limit", 64'(pend > MO), 0);
         end
         if (batch_done) begin
            ndone++;
            chk("done_before_all_rsp", 64'(qa.size() + pend), 0);
            extra = 3;
         end
         if (extra > 0) extra--;
         if (abort_after > 0 && nwr == abort_after) begin
            reset = 1;
            @(posedge clk);
            #1;
            check_all_zero("mid_reset");
            rbb_req_valid = 0;
            wr_almost_full = 0;
            wr_rsp_valid = 0;
            pend = 0;
            ack_prev = 0;
            err_exp = 0;
            reset = 0;
            return;
         end
      end
      chk("batch_timeout", 64'(extra), 0);
      chk("done_count", 64'(ndone), 1);
      chk("busy_end", busy, 0);
      chk("rsp_err_end", rsp_err, err_exp);
      if (early_exp >= 0) chk("early_writes", 64'(early), 64'(early_exp));
      wr_almost_full = 0;
      wr_rsp_valid = 0;
   endtask

   initial begin
      tbl[0] = '{32'h0000_1000, 0, 0, 0, -1, 1};
      tbl[1] = '{32'h0000_2000, 4, 10, 0, -1, 0};
      tbl[2] = '{32'h0000_3000, 0, 0, 30, 2, 0};
      tbl[3] = '{32'hFFFF_FFFE, 0, 0, 0, -1, 0};
      pend = 0;
      err_exp = 0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset_state");
      reset = 0;
      for (int v = 0; v < 4; v++)
         run_batch(tbl[v].base, tbl[v].af_start, tbl[v].af_len, tbl[v].rsp_hold,
                   tbl[v].early_exp, tbl[v].ack_chk, 0, 0);
      // stray response while idle must latch the error flag
      @(posedge clk);
      #1;
      wr_rsp_valid = 1;
      @(posedge clk);
      #1;
      wr_rsp_valid = 0;
      err_exp = 1;
      chk("rsp_err_set", rsp_err, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("rsp_err_sticky", rsp_err, 1);
      run_batch(32'h0000_4000, 0, 0, 0, -1, 0, 1, 0);
      run_batch(32'h0000_5000, 0, 0, 0, -1, 0, 0, 2);
      run_batch(32'h0000_5000, 0, 0, 0, -1, 1, 0, 0);
      for (int r = 0; r < 20; r++) run_batch($urandom, 0, 0, 0, -1, 0, 1, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
